// File: rtl/s_axis_cc_adapt_512b.sv
// s_axis_cc_adapt_512b
//   Converts legacy 512-bit completer-completion TLPs (3DW PCIe header in
//   DW0-DW2) into the CC descriptor format of the PCIe IP. Completion TLPs
//   (Cpl/CplD/CplLk/CplDLk) get their header rewritten on the first beat and
//   are forwarded. Any other TLP is swallowed, with a one-cycle drop_err pulse.
//   A 2-entry buffer registers the IP-side outputs and absorbs back-pressure.
//
// Ports
//   user_clk, user_reset      clock, synchronous active-high reset
//   s_axis_cc_t*              legacy user-side AXI-Stream (tuser[0] = discontinue)
//   s_axis_cc_t*_a            IP-side AXI-Stream (descriptor + payload, dword keep)
//   s_axis_cc_tready_a[3:0]   IP ready (all bits equal, bit 0 used)
//   drop_err                  pulse after a non-completion TLP is accepted
module s_axis_cc_adapt_512b #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter bit COMPLETER_ID_EN = 1'b0
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
  input  logic                  s_axis_cc_tlast,
  input  logic [3:0]            s_axis_cc_tuser,
  input  logic                  s_axis_cc_tvalid,
  output logic                  s_axis_cc_tready,
  output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
  output logic [15:0]           s_axis_cc_tkeep_a,
  output logic                  s_axis_cc_tlast_a,
  output logic [80:0]           s_axis_cc_tuser_a,
  output logic                  s_axis_cc_tvalid_a,
  input  logic [3:0]            s_axis_cc_tready_a,
  output logic                  drop_err
);

  typedef enum logic [1:0] {
    ST_SOP  = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e                state_q;
  logic                  drop_err_q;
  logic                  tready_q;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [15:0]           keep_q [2];
  logic                  last_q [2];
  logic [80:0]           user_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;

  logic                  accept_s;
  logic                  is_cpl_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  stay_drop_s;
  logic [95:0]           desc_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [15:0]           keep_a_s;
  logic [3:0]            eop_ptr_s;
  logic [80:0]           wr_user_s;
  logic                  unused_s;

  assign unused_s = ^{s_axis_cc_tuser[3:1], s_axis_cc_tready_a[3:1], s_axis_cc_tkeep};

  assign accept_s = s_axis_cc_tvalid & tready_q;
  assign is_cpl_s = (s_axis_cc_tdata[31:24] == 8'h0A) | (s_axis_cc_tdata[31:24] == 8'h4A) |
                    (s_axis_cc_tdata[31:24] == 8'h0B) | (s_axis_cc_tdata[31:24] == 8'h4B);
  // Only completion SOP beats and their continuation beats take buffer slots.
  assign push_s   = accept_s & ((state_q == ST_FWD) | ((state_q == ST_SOP) & is_cpl_s));
  assign pop_s    = s_axis_cc_tvalid_a & s_axis_cc_tready_a[0];

  // Legacy 3DW completion header -> CC descriptor
  always_comb begin
    desc_s        = 96'd0;
    desc_s[6:0]   = s_axis_cc_tdata[70:64];
    desc_s[28:16] = (s_axis_cc_tdata[43:32] == 12'd0) ? 13'h1000 : {1'b0, s_axis_cc_tdata[43:32]};
    desc_s[29]    = (s_axis_cc_tdata[28:24] == 5'b01011);
    desc_s[42:32] = (s_axis_cc_tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, s_axis_cc_tdata[9:0]};
    desc_s[45:43] = s_axis_cc_tdata[47:45];
    desc_s[46]    = s_axis_cc_tdata[14];
    desc_s[63:48] = s_axis_cc_tdata[95:80];
    desc_s[71:64] = s_axis_cc_tdata[79:72];
    desc_s[87:72] = s_axis_cc_tdata[63:48];
    desc_s[88]    = COMPLETER_ID_EN;
    desc_s[91:89] = s_axis_cc_tdata[22:20];
    desc_s[94:92] = {1'b0, s_axis_cc_tdata[13:12]};
  end

  // Dword keep, end-of-packet pointer and sideband for the incoming beat
  always_comb begin
    keep_a_s  = 16'd0;
    eop_ptr_s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      keep_a_s[i] = s_axis_cc_tkeep[4*i];
    end
    // Ascending scan: the last set bit seen wins, giving the highest index.
    for (int i = 0; i < 16; i++) begin
      eop_ptr_s = keep_a_s[i] ? 4'(i) : eop_ptr_s;
    end
    wr_user_s       = 81'd0;
    wr_user_s[0]    = (state_q == ST_SOP);
    wr_user_s[6]    = s_axis_cc_tlast;
    wr_user_s[11:8] = s_axis_cc_tlast ? eop_ptr_s : 4'd0;
    wr_user_s[16]   = s_axis_cc_tuser[0];
    wr_data_s       = (state_q == ST_SOP) ? {s_axis_cc_tdata[DATA_WIDTH-1:96], desc_s}
                                          : s_axis_cc_tdata;
  end

  // Buffer occupancy and whether the FSM will be discarding next cycle
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (accept_s) begin
      stay_drop_s = ~s_axis_cc_tlast & ((state_q == ST_DROP) | ((state_q == ST_SOP) & ~is_cpl_s));
    end else begin
      stay_drop_s = (state_q == ST_DROP);
    end
  end

  // Packet FSM, drop pulse and registered user-side ready
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q    <= ST_SOP;
      drop_err_q <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      drop_err_q <= accept_s & (state_q == ST_SOP) & ~is_cpl_s;
      // Discarding never fills the buffer, so ready stays up while dropping.
      tready_q   <= stay_drop_s | (count_d != 2'd2);
      case (state_q)
        ST_SOP: begin
          if (accept_s && !s_axis_cc_tlast) begin
            state_q <= is_cpl_s ? ST_FWD : ST_DROP;
          end
        end
        ST_FWD, ST_DROP: begin
          if (accept_s && s_axis_cc_tlast) begin
            state_q <= ST_SOP;
          end
        end
        default: state_q <= ST_SOP;
      endcase
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (push_s) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Buffer storage: forwarded beats land in the slot at the write pointer
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= {DATA_WIDTH{1'b0}};
        keep_q[i] <= 16'd0;
        last_q[i] <= 1'b0;
        user_q[i] <= 81'd0;
      end
    end else if (push_s) begin
      data_q[wr_ptr_q] <= wr_data_s;
      keep_q[wr_ptr_q] <= keep_a_s;
      last_q[wr_ptr_q] <= s_axis_cc_tlast;
      user_q[wr_ptr_q] <= wr_user_s;
    end
  end

  // Head slot drives the IP side; it cannot change until it is popped.
  assign s_axis_cc_tvalid_a = (count_q != 2'd0);
  assign s_axis_cc_tdata_a  = data_q[rd_ptr_q];
  assign s_axis_cc_tkeep_a  = keep_q[rd_ptr_q];
  assign s_axis_cc_tlast_a  = last_q[rd_ptr_q];
  assign s_axis_cc_tuser_a  = user_q[rd_ptr_q];
  assign s_axis_cc_tready   = tready_q;
  assign drop_err           = drop_err_q;

endmodule

// File: tb/tb_s_axis_cc_adapt_512b.sv
module tb_s_axis_cc_adapt_512b;

  logic         clk = 1'b0;
  logic         user_reset;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic [3:0]   tuser;
  logic         tvalid;
  logic         tready;
  logic [511:0] tdata_a;
  logic [15:0]  tkeep_a;
  logic         tlast_a;
  logic [80:0]  tuser_a;
  logic         tvalid_a;
  logic [3:0]   tready_a;
  logic         drop_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  s_axis_cc_adapt_512b dut (
    .user_clk           (clk),
    .user_reset         (user_reset),
    .s_axis_cc_tdata    (tdata),
    .s_axis_cc_tkeep    (tkeep),
    .s_axis_cc_tlast    (tlast),
    .s_axis_cc_tuser    (tuser),
    .s_axis_cc_tvalid   (tvalid),
    .s_axis_cc_tready   (tready),
    .s_axis_cc_tdata_a  (tdata_a),
    .s_axis_cc_tkeep_a  (tkeep_a),
    .s_axis_cc_tlast_a  (tlast_a),
    .s_axis_cc_tuser_a  (tuser_a),
    .s_axis_cc_tvalid_a (tvalid_a),
    .s_axis_cc_tready_a (tready_a),
    .drop_err           (drop_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k,
                            input logic l, input logic [3:0] u);
    int n;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tuser  = u;
    tvalid = 1'b1;
    n      = 0;
    while (tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      failures++;
      $error("FAIL accept_timeout observed=%0d expected<50", n);
    end
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  logic [511:0] cpl_a, exp_a, cpl_b, exp_b, c1, exp_c1, c2, c3, mwr1, mwr2, f2;

  initial begin
    cpl_a  = {384'd0, 32'hDEADBEEF, 32'hABCD2A04, 32'h12340004, 32'h4A000001};
    exp_a  = {384'd0, 32'hDEADBEEF, 32'h0012342A, 32'hABCD0001, 32'h00040004};
    cpl_b  = {416'd0, 32'h01027F7F, 32'h55556000, 32'h0B506000};
    exp_b  = {416'd0, 32'h2A55557F, 32'h01025C00, 32'h3000007F};
    c1     = {{13{32'hC1C1C1C1}}, 32'h00000000, 32'h00000080, 32'h4A000020};
    exp_c1 = {{13{32'hC1C1C1C1}}, 32'h00000000, 32'h00000020, 32'h00800000};
    c2     = {16{32'hC2C2C2C2}};
    c3     = {16{32'hC3C3C3C3}};
    mwr1   = {{13{32'hD1D1D1D1}}, 32'h0, 32'h0, 32'h40000001};
    mwr2   = {16{32'hD2D2D2D2}};
    f2     = {16{32'hF2F2F2F2}};

    user_reset = 1'b1;
    tvalid     = 1'b0;
    tdata      = 512'd0;
    tkeep      = 64'd0;
    tlast      = 1'b0;
    tuser      = 4'd0;
    tready_a   = 4'hF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", tready, 1'b0);
    chk("rst_tvalid_a", tvalid_a, 1'b0);
    chk("rst_tlast_a", tlast_a, 1'b0);
    chk("rst_drop_err", drop_err, 1'b0);
    user_reset = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", tready, 1'b1);

    // Single-beat CplD with header rewrite
    drive_beat(cpl_a, 64'h0000_0000_0000_FFFF, 1'b1, 4'd0);
    chk("a_tvalid", tvalid_a, 1'b1);
    chk("a_data", tdata_a, exp_a);
    chk("a_keep", tkeep_a, 16'h000F);
    chk("a_last", tlast_a, 1'b1);
    chk("a_user", tuser_a, 81'h341);
    chk("a_drop_err", drop_err, 1'b0);
    @(negedge clk);
    chk("a_single_beat", tvalid_a, 1'b0);

    // Locked completion, len 0 and byte_count 0, with TC/attr/EP/status
    drive_beat(cpl_b, 64'h0000_0000_0000_0FFF, 1'b1, 4'd0);
    chk("b_data", tdata_a, exp_b);
    chk("b_keep", tkeep_a, 16'h0007);
    chk("b_user", tuser_a, 81'h241);

    // 3-beat CplD with a 3-cycle IP stall
    drive_beat(c1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0);
    chk("c1_data", tdata_a, exp_c1);
    chk("c1_keep", tkeep_a, 16'hFFFF);
    chk("c1_user", tuser_a, 81'h1);
    chk("c1_last", tlast_a, 1'b0);
    tready_a = 4'h0;
    drive_beat(c2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0);
    chk("c_full_tready", tready, 1'b0);
    chk("c_stall0_data", tdata_a, exp_c1);
    chk("c_stall0_valid", tvalid_a, 1'b1);
    @(negedge clk);
    chk("c_stall1_data", tdata_a, exp_c1);
    chk("c_stall1_user", tuser_a, 81'h1);
    @(negedge clk);
    chk("c_stall2_data", tdata_a, exp_c1);
    chk("c_stall2_last", tlast_a, 1'b0);
    tready_a = 4'hF;
    @(negedge clk);
    chk("c2_data", tdata_a, c2);
    chk("c2_user", tuser_a, 81'h0);
    chk("c2_last", tlast_a, 1'b0);
    chk("c_tready_back", tready, 1'b1);
    drive_beat(c3, 64'h0000_0000_0000_FFFF, 1'b1, 4'd0);
    chk("c3_data", tdata_a, c3);
    chk("c3_last", tlast_a, 1'b1);
    chk("c3_keep", tkeep_a, 16'h000F);
    chk("c3_user", tuser_a, 81'h340);
    @(negedge clk);
    chk("c_done", tvalid_a, 1'b0);

    // 2-beat MWr is discarded, then a CplD passes intact
    tready_a = 4'h0;
    drive_beat(mwr1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0);
    chk("d_mwr1_valid", tvalid_a, 1'b0);
    chk("d_drop_pulse", drop_err, 1'b1);
    drive_beat(mwr2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    chk("d_mwr2_valid", tvalid_a, 1'b0);
    chk("d_drop_once", drop_err, 1'b0);
    tready_a = 4'hF;
    drive_beat(cpl_a, 64'h0000_0000_0000_FFFF, 1'b1, 4'd0);
    chk("d_cpl_data", tdata_a, exp_a);
    chk("d_cpl_user", tuser_a, 81'h341);
    chk("d_cpl_drop_err", drop_err, 1'b0);

    // Reset after beat 1 of 3 discards the partial TLP
    drive_beat(c1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0);
    chk("e_beat1_valid", tvalid_a, 1'b1);
    tready_a   = 4'h0;
    user_reset = 1'b1;
    @(negedge clk);
    chk("e_rst_valid", tvalid_a, 1'b0);
    chk("e_rst_tready", tready, 1'b0);
    user_reset = 1'b0;
    tready_a   = 4'hF;
    @(negedge clk);
    chk("e_tready", tready, 1'b1);
    drive_beat(cpl_a, 64'h0000_0000_0000_FFFF, 1'b1, 4'd0);
    chk("e_sop_user", tuser_a, 81'h341);
    chk("e_sop_data", tdata_a, exp_a);

    // Discontinue on the last beat only
    drive_beat(c1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0);
    chk("f1_user", tuser_a, 81'h1);
    drive_beat(f2, 64'h0000_0000_00FF_FFFF, 1'b1, 4'b1001);
    chk("f2_data", tdata_a, f2);
    chk("f2_keep", tkeep_a, 16'h003F);
    chk("f2_user", tuser_a, 81'h10540);
    @(negedge clk);
    chk("f_done", tvalid_a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
